// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux scan sequencer.
package mux_scan_pkg;

   localparam int unsigned NCH   = 4;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned IDX_W = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DWELL = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_DWELL = ST_DWELL,
      S_DONE  = ST_DONE
   } state_t;

   typedef logic [NCH-1:0] chan_vec_t;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Captured-word handshake between the scanner (master) and its consumer (slave).
interface mux_scan_sequencer_if;
   import mux_scan_pkg::*;

   chan_vec_t sample;
   logic      sample_valid;
   logic      sample_ready;

   modport master (output sample, output sample_valid, input sample_ready);
   modport slave  (input sample, input sample_valid, output sample_ready);

endinterface

// File: rtl/next_chan_pick.sv
// Finds the next higher enabled channel above cur_idx; from_start treats
// cur_idx as -1 so the lowest enabled channel is returned.
module next_chan_pick
   import mux_scan_pkg::*;
(
   input  chan_vec_t        mask_q,
   input  logic             from_start,
   input  logic [IDX_W-1:0] cur_idx,
   output logic [IDX_W-1:0] next_idx_c,
   output logic             none_c
);

   // Scan high to low so the lowest qualifying channel wins.
   always_comb begin
      next_idx_c = '0;
      none_c     = 1'b1;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask_q[i] && (from_start || (IDX_W'(i) > cur_idx))) begin
            next_idx_c = IDX_W'(i);
            none_c     = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 4:1 mux select through each enabled channel, dwells DWELL cycles,
// captures mux_out, and offers the 4-bit word over a valid/ready handshake.
// Optional feature: define MUX_SCAN_CONTINUOUS_EN to allow a new scan to
// launch directly on the transfer edge when start is high.
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int unsigned DWELL = 3
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  chan_vec_t            mask,
   input  logic                 mux_out,
   output logic [SEL_W-1:0]     sel,
   output logic                 busy,
   mux_scan_sequencer_if.master bus
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   chan_vec_t        mask_q, mask_d;
   chan_vec_t        sample_q, sample_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             launch;

   logic [IDX_W-1:0] first_idx, next_idx;
   logic             first_none, next_none;

   // First enabled channel of the incoming mask (used at launch).
   next_chan_pick u_first_pick (
      .mask_q     (mask),
      .from_start (1'b1),
      .cur_idx    ('0),
      .next_idx_c (first_idx),
      .none_c     (first_none)
   );

   // Next enabled channel above the current one in the latched mask.
   next_chan_pick u_next_pick (
      .mask_q     (mask_q),
      .from_start (1'b0),
      .cur_idx    (sel_q[IDX_W-1:0]),
      .next_idx_c (next_idx),
      .none_c     (next_none)
   );

   // State, counter, capture and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sel_q    <= '0;
         cnt_q    <= '0;
         mask_q   <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   // Next-state, dwell counting, capture and launch of a new scan.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      sample_d = sample_q;
      launch   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            launch = start;
         end
         S_DWELL: begin
            if (cnt_q == '0) begin
               sample_d[sel_q[IDX_W-1:0]] = mux_out;
               if (next_none) begin
                  state_d = S_DONE;
               end else begin
                  sel_d = SEL_W'(next_idx);
                  cnt_d = RELOAD;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
            if (bus.sample_ready) begin
               state_d = S_IDLE;
`ifdef MUX_SCAN_CONTINUOUS_EN
               launch  = start;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (launch) begin
         mask_d   = mask;
         sample_d = '0;
         if (first_none) begin
            state_d = S_DONE;
            sel_d   = '0;
         end else begin
            state_d = S_DWELL;
            sel_d   = SEL_W'(first_idx);
            cnt_d   = RELOAD;
         end
      end

      busy_d  = (state_d != S_IDLE);
      valid_d = (state_d == S_DONE);
   end

   assign sel              = sel_q;
   assign busy             = busy_q;
   assign bus.sample       = sample_q;
   assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer (DWELL=3).
module tb_mux_scan_sequencer;
   import mux_scan_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] mask;
   logic [3:0] pattern;
   logic       mux_out;
   logic [2:0] sel;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   mux_scan_sequencer_if bus ();

   mux_scan_sequencer #(.DWELL(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .mask    (mask),
      .mux_out (mux_out),
      .sel     (sel),
      .busy    (busy),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Mux model: output is the pattern bit selected by sel.
   always_comb mux_out = pattern[sel[1:0]];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      mask = 4'b0000;
      pattern = 4'b0000;
      bus.sample_ready = 1'b0;
      #12;
      n_checks++; if (sel !== 3'b000) begin n_fail++; $display("FAIL reset_sel got %b want 000", sel); end
      n_checks++; if (bus.sample !== 4'b0000) begin n_fail++; $display("FAIL reset_sample got %b want 0000", bus.sample); end
      n_checks++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.sample_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_full_scan;
      pattern = 4'b1010;
      mask = 4'b1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      mask = 4'b0000;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy got %b want 1", busy); end
      for (int c = 0; c < 12; c++) begin
         n_checks++; if (sel !== 3'(c / 3)) begin n_fail++; $display("FAIL full_sel c=%0d got %0d want %0d", c, sel, c / 3); end
         n_checks++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid c=%0d got %b want 0", c, bus.sample_valid); end
         tick();
      end
      n_checks++; if (bus.sample_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %b want 1", bus.sample_valid); end
      n_checks++; if (bus.sample !== 4'b1010) begin n_fail++; $display("FAIL full_sample got %b want 1010", bus.sample); end
      n_checks++; if (sel !== 3'd3) begin n_fail++; $display("FAIL full_sel_frozen got %0d want 3", sel); end
      bus.sample_ready = 1'b1;
      tick();
      bus.sample_ready = 1'b0;
      n_checks++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_fall got %b want 0", bus.sample_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_fall got %b want 0", busy); end
   endtask

   task automatic test_sparse;
      pattern = 4'b1111;
      mask = 4'b0101;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 6; c++) begin
         n_checks++; if (sel !== ((c < 3) ? 3'd0 : 3'd2)) begin n_fail++; $display("FAIL sparse_sel c=%0d got %0d", c, sel); end
         n_checks++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL sparse_early_valid c=%0d got %b want 0", c, bus.sample_valid); end
         tick();
      end
      n_checks++; if (bus.sample_valid !== 1'b1) begin n_fail++; $display("FAIL sparse_valid got %b want 1", bus.sample_valid); end
      n_checks++; if (bus.sample !== 4'b0101) begin n_fail++; $display("FAIL sparse_sample got %b want 0101", bus.sample); end
      bus.sample_ready = 1'b1;
      tick();
      bus.sample_ready = 1'b0;
      n_checks++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL sparse_valid_fall got %b want 0", bus.sample_valid); end
   endtask

   task automatic test_empty;
      pattern = 4'b1111;
      mask = 4'b0000;
      n_checks++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pre_valid got %b want 0", bus.sample_valid); end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++; if (bus.sample_valid !== 1'b1) begin n_fail++; $display("FAIL empty_valid got %b want 1", bus.sample_valid); end
      n_checks++; if (bus.sample !== 4'b0000) begin n_fail++; $display("FAIL empty_sample got %b want 0000", bus.sample); end
      n_checks++; if (sel !== 3'b000) begin n_fail++; $display("FAIL empty_sel got %b want 000", sel); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy got %b want 1", busy); end
      bus.sample_ready = 1'b1;
      tick();
      bus.sample_ready = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy_fall got %b want 0", busy); end
   endtask

   task automatic test_backpressure;
      pattern = 4'b0001;
      mask = 4'b0011;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      n_checks++; if (bus.sample_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", bus.sample_valid); end
      for (int c = 0; c < 10; c++) begin
         start = c[0];
         mask = 4'b1111;
         n_checks++; if (bus.sample_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c=%0d got %b want 1", c, bus.sample_valid); end
         n_checks++; if (bus.sample !== 4'b0001) begin n_fail++; $display("FAIL bp_hold_sample c=%0d got %b want 0001", c, bus.sample); end
         n_checks++; if (sel !== 3'd1) begin n_fail++; $display("FAIL bp_hold_sel c=%0d got %0d want 1", c, sel); end
         n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_hold_busy c=%0d got %b want 1", c, busy); end
         tick();
      end
      start = 1'b0;
      bus.sample_ready = 1'b1;
      tick();
      bus.sample_ready = 1'b0;
      n_checks++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_fall got %b want 0", bus.sample_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_fall got %b want 0", busy); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_stays_idle got %b want 0", busy); end
   endtask

   task automatic test_mid_reset;
      pattern = 4'b1111;
      mask = 4'b1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      n_checks++; if (sel !== 3'd2) begin n_fail++; $display("FAIL mr_sel_before got %0d want 2", sel); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (sel !== 3'b000) begin n_fail++; $display("FAIL mr_sel got %b want 000", sel); end
      n_checks++; if (bus.sample !== 4'b0000) begin n_fail++; $display("FAIL mr_sample got %b want 0000", bus.sample); end
      n_checks++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid got %b want 0", bus.sample_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy got %b want 0", busy); end
      #1;
      rst_n = 1'b1;
      tick();
      for (int c = 0; c < 15; c++) begin
         n_checks++; if (bus.sample_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mr_no_restart c=%0d valid %b busy %b want 0 0", c, bus.sample_valid, busy); end
         tick();
      end
   endtask

   task automatic test_back_to_back;
`ifdef MUX_SCAN_CONTINUOUS_EN
      pattern = 4'b0011;
      mask = 4'b0001;
      start = 1'b1;
      bus.sample_ready = 1'b1;
      tick();
      repeat (3) tick();
      n_checks++; if (bus.sample_valid !== 1'b1) begin n_fail++; $display("FAIL cont_valid1 got %b want 1", bus.sample_valid); end
      n_checks++; if (bus.sample !== 4'b0001) begin n_fail++; $display("FAIL cont_sample1 got %b want 0001", bus.sample); end
      mask = 4'b0010;
      tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy got %b want 1", busy); end
      n_checks++; if (bus.sample_valid !== 1'b0) begin n_fail++; $display("FAIL cont_valid_drop got %b want 0", bus.sample_valid); end
      n_checks++; if (sel !== 3'd1) begin n_fail++; $display("FAIL cont_sel got %0d want 1", sel); end
      repeat (3) tick();
      n_checks++; if (bus.sample_valid !== 1'b1) begin n_fail++; $display("FAIL cont_valid2 got %b want 1", bus.sample_valid); end
      n_checks++; if (bus.sample !== 4'b0010) begin n_fail++; $display("FAIL cont_sample2 got %b want 0010", bus.sample); end
      start = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_idle got %b want 0", busy); end
      bus.sample_ready = 1'b0;
`else
      pattern = 4'b0001;
      mask = 4'b0001;
      start = 1'b1;
      bus.sample_ready = 1'b1;
      tick();
      repeat (3) tick();
      n_checks++; if (bus.sample_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", bus.sample_valid); end
      n_checks++; if (bus.sample !== 4'b0001) begin n_fail++; $display("FAIL b2b_sample got %b want 0001", bus.sample); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap got %b want 0", busy); end
      tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_relaunch got %b want 1", busy); end
      start = 1'b0;
      repeat (3) tick();
      n_checks++; if (bus.sample_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2 got %b want 1", bus.sample_valid); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_final_idle got %b want 0", busy); end
      bus.sample_ready = 1'b0;
`endif
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_sparse();
      test_empty();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
